// File: rtl/shared_reg_arb_if.sv
// Bus bundle for the shared result register arbiter.
// Requester, forward and output handshakes in one interface.
interface shared_reg_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int SW    = $clog2(NREQ + 1)
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fwd_valid;
  logic [WIDTH-1:0]      fwd_data;
  logic                  fwd_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SW-1:0]         out_src;
  logic                  out_ready;

  modport master (
    output req_valid, req_data,
    output fwd_valid, fwd_data,
    output out_ready,
    input  req_ready, fwd_ready,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data,
    input  fwd_valid, fwd_data,
    input  out_ready,
    output req_ready, fwd_ready,
    output out_valid, out_data, out_src
  );
endinterface

// File: rtl/shared_reg_arb.sv
// Shared pipelined result register: forward source first,
// round-robin requesters, forward streak capped to avoid starvation.
module shared_reg_arb #(
  parameter int WIDTH  = 32,
  parameter int NREQ   = 3,
  parameter int LAT    = 1,
  parameter int MAXFWD = 3
) (
  input  logic            clk,
  input  logic            rst,
  shared_reg_arb_if.slave bus
);
  localparam int SW = $clog2(NREQ + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LAT-1:0]   vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [LAT];
  logic [WIDTH-1:0] dat_d [LAT];
  logic [SW-1:0]    src_q [LAT];
  logic [SW-1:0]    src_d [LAT];
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]       fwd_cnt_q, fwd_cnt_d;

  logic            ok_out;
  logic            ok_in;
  logic            arb_en;
  logic            req_any;
  logic            fwd_win;
  logic            gnt_hit;
  logic            take;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     cand;
  logic [NREQ-1:0] req_gnt;

  // Stage readiness ripples back from the output in the same cycle.
  assign ok_out  = ~vld_q[LAT-1] | bus.out_ready;
  assign ok_in   = ~vld_q[0] | ok_out;
  assign arb_en  = ok_in & ~rst;
  assign req_any = |bus.req_valid;
  assign fwd_win = bus.fwd_valid &
                   (~req_any | (fwd_cnt_q < 4'(MAXFWD)));

  // Scan from farthest to nearest so the nearest valid wins.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(off);
      if (cand >= (PW+1)'(NREQ))
        cand = cand - (PW+1)'(NREQ);
      if (bus.req_valid[cand[PW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    req_gnt = '0;
    if (arb_en & ~fwd_win & gnt_hit)
      req_gnt[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = req_gnt;
  assign bus.fwd_ready = arb_en & fwd_win;
  assign take          = bus.fwd_ready | (|req_gnt);

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    src_d = src_q;
    if (ok_out) begin
      for (int k = 1; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_d[k] = dat_q[k-1];
          src_d[k] = src_q[k-1];
        end
      end
    end
    if (ok_in) begin
      vld_d[0] = take;
      if (take) begin
        if (fwd_win) begin
          dat_d[0] = bus.fwd_data;
          src_d[0] = SW'(NREQ);
        end else begin
          dat_d[0] = bus.req_data[int'(gnt_idx)*WIDTH +: WIDTH];
          src_d[0] = SW'(gnt_idx);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d  = (|req_gnt) ? gnt_idx : rr_ptr_q;
    fwd_cnt_d = fwd_cnt_q;
    if (!req_any)
      fwd_cnt_d = '0;
    else if (bus.fwd_ready && fwd_cnt_q < 4'(MAXFWD))
      fwd_cnt_d = fwd_cnt_q + 4'd1;
    else if (|req_gnt)
      fwd_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      for (int k = 0; k < LAT; k++) begin
        dat_q[k] <= '0;
        src_q[k] <= '0;
      end
      rr_ptr_q  <= PW'(NREQ - 1);
      fwd_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      src_q     <= src_d;
      rr_ptr_q  <= rr_ptr_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.out_data  = dat_q[LAT-1];
  assign bus.out_src   = src_q[LAT-1];
endmodule
